// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RISC-V core: sequences the shared memory, ALU and register file.
// Optional INSTRET_COUNTER_EN adds a retired-instruction counter on o_instret; otherwise o_instret is 0.
module multicycle_controller (
  input  logic        i_clk,
  input  logic        i_arst_n,
  input  logic [6:0]  i_operand,
  input  logic [2:0]  i_funct3,
  input  logic        i_funct7bit5,
  input  logic        i_zero,
  input  logic        i_memReady,
  output logic        o_pcWriteEn,
  output logic        o_adrSel,
  output logic        o_memReadEn,
  output logic        o_memWriteEn,
  output logic        o_irWriteEn,
  output logic        o_regWriteEn,
  output logic [1:0]  o_resultSel,
  output logic [1:0]  o_aluSrcA,
  output logic [1:0]  o_aluSrcB,
  output logic [3:0]  o_aluLogicOperation,
  output logic        o_illegal,
  output logic [31:0] o_instret
);

  localparam logic [6:0] opLoad   = 7'b0000011;
  localparam logic [6:0] opStore  = 7'b0100011;
  localparam logic [6:0] opRType  = 7'b0110011;
  localparam logic [6:0] opIAlu   = 7'b0010011;
  localparam logic [6:0] opBranch = 7'b1100011;
  localparam logic [6:0] opJal    = 7'b1101111;

  localparam logic [3:0] aluAdd = 4'h0;
  localparam logic [3:0] aluSub = 4'h1;
  localparam logic [3:0] aluAnd = 4'h2;
  localparam logic [3:0] aluOr  = 4'h3;
  localparam logic [3:0] aluXor = 4'h4;
  localparam logic [3:0] aluSlt = 4'h5;

  typedef enum logic [3:0] {
    sFetch, sDecode, sMemAdr, sMemRead, sMemWb, sMemWrite,
    sExecuteR, sExecuteI, sAluWb, sBeq, sJal, sIllegal
  } stateT;

  stateT state;

  function automatic logic funct3Legal(input logic [2:0] f3);
    return f3 inside {3'b000, 3'b010, 3'b100, 3'b110, 3'b111};
  endfunction

  function automatic logic [3:0] aluOpFor(input logic [2:0] f3, input logic subAllowed, input logic f7);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (subAllowed && f7) ? aluSub : aluAdd;
      3'b010:  op = aluSlt;
      3'b100:  op = aluXor;
      3'b110:  op = aluOr;
      3'b111:  op = aluAnd;
      default: op = aluAdd;
    endcase
    return op;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state <= sFetch;
    end else begin
      case (state)
        sFetch:    if (i_memReady) state <= sDecode;
        sDecode: begin
          case (i_operand)
            opLoad, opStore: state <= sMemAdr;
            opRType:         state <= funct3Legal(i_funct3) ? sExecuteR : sIllegal;
            opIAlu:          state <= funct3Legal(i_funct3) ? sExecuteI : sIllegal;
            opBranch:        state <= sBeq;
            opJal:           state <= sJal;
            default:         state <= sIllegal;
          endcase
        end
        sMemAdr:   state <= (i_operand == opLoad) ? sMemRead : sMemWrite;
        sMemRead:  if (i_memReady) state <= sMemWb;
        sMemWb:    state <= sFetch;
        sMemWrite: if (i_memReady) state <= sFetch;
        sExecuteR, sExecuteI: state <= sAluWb;
        sAluWb:    state <= sFetch;
        sBeq:      state <= sFetch;
        sJal:      state <= sAluWb;
        sIllegal:  state <= sIllegal;
        default:   state <= sFetch;
      endcase
    end
  end

  // Outputs are decoded from state (plus handshake/zero inputs) and forced low during reset,
  // so an access in flight loses its request the moment reset asserts.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    o_pcWriteEn         = 1'b0;
    o_adrSel            = 1'b0;
    o_memReadEn         = 1'b0;
    o_memWriteEn        = 1'b0;
    o_irWriteEn         = 1'b0;
    o_regWriteEn        = 1'b0;
    o_resultSel         = 2'b00;
    o_aluSrcA           = 2'b00;
    o_aluSrcB           = 2'b00;
    o_aluLogicOperation = aluAdd;
    o_illegal           = 1'b0;
    if (i_arst_n) begin
      case (state)
        sFetch: begin
          o_memReadEn = 1'b1;
          o_aluSrcB   = 2'b10;
          o_resultSel = 2'b10;
          o_irWriteEn = i_memReady;
          o_pcWriteEn = i_memReady;
        end
        sDecode: begin
          o_aluSrcA = 2'b01;
          o_aluSrcB = 2'b01;
        end
        sMemAdr: begin
          o_aluSrcA = 2'b10;
          o_aluSrcB = 2'b01;
        end
        sMemRead: begin
          o_adrSel    = 1'b1;
          o_memReadEn = 1'b1;
        end
        sMemWb: begin
          o_resultSel  = 2'b01;
          o_regWriteEn = 1'b1;
        end
        sMemWrite: begin
          o_adrSel     = 1'b1;
          o_memWriteEn = 1'b1;
        end
        sExecuteR: begin
          o_aluSrcA           = 2'b10;
          o_aluLogicOperation = aluOpFor(i_funct3, 1'b1, i_funct7bit5);
        end
        sExecuteI: begin
          o_aluSrcA           = 2'b10;
          o_aluSrcB           = 2'b01;
          o_aluLogicOperation = aluOpFor(i_funct3, 1'b0, i_funct7bit5);
        end
        sAluWb:    o_regWriteEn = 1'b1;
        sBeq: begin
          o_aluSrcA           = 2'b10;
          o_aluLogicOperation = aluSub;
          o_pcWriteEn         = i_zero;
        end
        sJal: begin
          o_aluSrcA   = 2'b01;
          o_aluSrcB   = 2'b10;
          o_pcWriteEn = 1'b1;
        end
        sIllegal:  o_illegal = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef INSTRET_COUNTER_EN
  logic [31:0] instretCount;
  logic        retire;

  // jal retires through ALUWB, so it is counted exactly once.
  assign retire = (state == sMemWb) || (state == sAluWb) || (state == sBeq) ||
                  ((state == sMemWrite) && i_memReady);

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n)   instretCount <= '0;
    else if (retire) instretCount <= instretCount + 32'd1;
  end

  assign o_instret = instretCount;
`else
  assign o_instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: an instruction-level model expands each instruction into its expected
// per-cycle control vector; every cycle of the DUT is compared against that schedule.
module tb_multicycle_controller;

  logic        i_clk = 1'b0;
  logic        i_arst_n = 1'b0;
  logic [6:0]  i_operand = '0;
  logic [2:0]  i_funct3 = '0;
  logic        i_funct7bit5 = 1'b0;
  logic        i_zero = 1'b0;
  logic        i_memReady = 1'b0;
  logic        o_pcWriteEn, o_adrSel, o_memReadEn, o_memWriteEn, o_irWriteEn, o_regWriteEn;
  logic [1:0]  o_resultSel, o_aluSrcA, o_aluSrcB;
  logic [3:0]  o_aluLogicOperation;
  logic        o_illegal;
  logic [31:0] o_instret;

  multicycle_controller dut (
    .i_clk(i_clk), .i_arst_n(i_arst_n), .i_operand(i_operand), .i_funct3(i_funct3),
    .i_funct7bit5(i_funct7bit5), .i_zero(i_zero), .i_memReady(i_memReady),
    .o_pcWriteEn(o_pcWriteEn), .o_adrSel(o_adrSel), .o_memReadEn(o_memReadEn),
    .o_memWriteEn(o_memWriteEn), .o_irWriteEn(o_irWriteEn), .o_regWriteEn(o_regWriteEn),
    .o_resultSel(o_resultSel), .o_aluSrcA(o_aluSrcA), .o_aluSrcB(o_aluSrcB),
    .o_aluLogicOperation(o_aluLogicOperation), .o_illegal(o_illegal), .o_instret(o_instret)
  );

  always #5 i_clk = ~i_clk;

  localparam logic [6:0] opLoad = 7'b0000011, opStore = 7'b0100011, opR = 7'b0110011;
  localparam logic [6:0] opI = 7'b0010011, opBeq = 7'b1100011, opJal = 7'b1101111;

  typedef struct packed {
    logic pcW, adrSel, memR, memW, irW, regW;
    logic [1:0] res, srcA, srcB;
    logic [3:0] op;
    logic ill;
    logic [31:0] instret;
  } outsT;

  typedef struct {
    logic rstN;
    logic [6:0] opc;
    logic [2:0] f3;
    logic f7, zero, ready;
    outsT exp;
    string tag;
  } cycT;

  cycT sched[$];
  int errors = 0;
  int checks = 0;
  int unsigned expCount = 0;
  int cycleNo = 0;
  logic [6:0] cOpc;
  logic [2:0] cF3;
  logic cF7;
  int obsPcW, obsRegW, obsMemRd, obsIll;
  logic [3:0] obsExecOp;
  logic [31:0] obsFirstInstret;
  logic releasePending = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic outsT base();
    outsT o = '0;
`ifdef INSTRET_COUNTER_EN
    o.instret = expCount;
`endif
    return o;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic ready, input logic zero, input outsT e, input string tag);
    cycT c;
    c.rstN = 1'b1; c.opc = cOpc; c.f3 = cF3; c.f7 = cF7;
    c.zero = zero; c.ready = ready; c.exp = e; c.tag = tag;
    sched.push_back(c);
  endtask

  task automatic pushReset();
    cycT c;
    c.rstN = 1'b0; c.opc = 7'($urandom); c.f3 = 3'($urandom); c.f7 = rnd();
    c.zero = rnd(); c.ready = rnd(); c.exp = '0; c.tag = "RESET";
    sched.push_back(c);
    expCount = 0;
  endtask

  // Spec-level ALU operation table for the execute stage.
  function automatic logic [3:0] expAluOp(input logic [2:0] f3, input logic isR, input logic f7);
    case (f3)
      3'b000:  return (isR && f7) ? 4'h1 : 4'h0;
      3'b010:  return 4'h5;
      3'b100:  return 4'h4;
      3'b110:  return 4'h3;
      3'b111:  return 4'h2;
      default: return 4'hF;
    endcase
  endfunction

  task automatic illegalRun();
    outsT e;
    for (int i = 0; i < 20; i++) begin
      e = base(); e.ill = 1'b1;
      push(rnd(), rnd(), e, "ILLEGAL");
    end
    pushReset();
  endtask

  // Expand one instruction into its expected cycles; abortMem resets during a stalled access.
  task automatic instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7, input logic zero,
                       input int wF, input int wM, input logic abortMem);
    outsT e;
    cOpc = opc; cF3 = f3; cF7 = f7;
    for (int i = 0; i <= wF; i++) begin
      e = base(); e.memR = 1'b1; e.srcB = 2'b10; e.res = 2'b10;
      e.irW = (i == wF); e.pcW = (i == wF);
      push(i == wF, rnd(), e, "FETCH");
    end
    e = base(); e.srcA = 2'b01; e.srcB = 2'b01;
    push(rnd(), rnd(), e, "DECODE");
    if (opc == opLoad || opc == opStore) begin
      e = base(); e.srcA = 2'b10; e.srcB = 2'b01;
      push(rnd(), rnd(), e, "MEMADR");
      for (int i = 0; i <= wM; i++) begin
        if (abortMem && i == wM) begin
          pushReset();
          return;
        end
        e = base(); e.adrSel = 1'b1;
        if (opc == opLoad) e.memR = 1'b1; else e.memW = 1'b1;
        push(i == wM, rnd(), e, "MEMACCESS");
      end
      if (opc == opLoad) begin
        e = base(); e.res = 2'b01; e.regW = 1'b1;
        push(rnd(), rnd(), e, "MEMWB");
      end
      expCount++;
    end else if (opc == opR || opc == opI) begin
      if (expAluOp(f3, 1'b0, 1'b0) == 4'hF) begin
        illegalRun();
        return;
      end
      e = base(); e.srcA = 2'b10; e.srcB = (opc == opR) ? 2'b00 : 2'b01;
      e.op = expAluOp(f3, opc == opR, f7);
      push(rnd(), rnd(), e, "EXECUTE");
      e = base(); e.regW = 1'b1;
      push(rnd(), rnd(), e, "ALUWB");
      expCount++;
    end else if (opc == opBeq) begin
      e = base(); e.srcA = 2'b10; e.op = 4'h1; e.pcW = zero;
      push(rnd(), zero, e, "BEQ");
      expCount++;
    end else if (opc == opJal) begin
      e = base(); e.srcA = 2'b01; e.srcB = 2'b10; e.pcW = 1'b1;
      push(rnd(), rnd(), e, "JAL");
      e = base(); e.regW = 1'b1;
      push(rnd(), rnd(), e, "ALUWB");
      expCount++;
    end else begin
      illegalRun();
    end
  endtask

  function automatic outsT dutOuts();
    outsT o;
    o.pcW = o_pcWriteEn; o.adrSel = o_adrSel; o.memR = o_memReadEn; o.memW = o_memWriteEn;
    o.irW = o_irWriteEn; o.regW = o_regWriteEn; o.res = o_resultSel; o.srcA = o_aluSrcA;
    o.srcB = o_aluSrcB; o.op = o_aluLogicOperation; o.ill = o_illegal; o.instret = o_instret;
    return o;
  endfunction

  // Drive each scheduled cycle just after the rising edge, compare on the falling edge.
  task automatic runSched();
    obsPcW = 0; obsRegW = 0; obsMemRd = 0; obsIll = 0; obsExecOp = 'x; obsFirstInstret = 'x;
    foreach (sched[i]) begin
      @(posedge i_clk);
      #1;
      i_arst_n = sched[i].rstN; i_operand = sched[i].opc; i_funct3 = sched[i].f3;
      i_funct7bit5 = sched[i].f7; i_zero = sched[i].zero; i_memReady = sched[i].ready;
      @(negedge i_clk);
      check($sformatf("cycle %0d %s outputs", cycleNo, sched[i].tag), 64'(dutOuts()), 64'(sched[i].exp));
      if (i == 0) obsFirstInstret = o_instret;
      if (sched[i].tag == "EXECUTE") obsExecOp = o_aluLogicOperation;
      obsPcW += int'(o_pcWriteEn);
      obsRegW += int'(o_regWriteEn);
      obsMemRd += int'(o_adrSel && o_memReadEn);
      obsIll += int'(o_illegal);
      cycleNo++;
`ifdef INSTRET_COUNTER_EN
      if (releasePending) begin
        release dut.instretCount;
        releasePending = 1'b0;
      end
`endif
    end
    sched.delete();
  endtask

  initial begin
    int len;
    int k;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [2:0] legalF3 [5] = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b111};

    pushReset(); pushReset();
    runSched();

    instr(opR, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
    len = sched.size();
    check("add latency", 64'(len), 64'd4);
    runSched();
    check("add exec op", 64'(obsExecOp), 64'h0);
    check("add regwrite pulses", 64'(obsRegW), 64'd1);

    instr(opLoad, 3'b010, 1'b0, 1'b0, 0, 3, 1'b0);
    check("lw latency with 3 waits", 64'(sched.size()), 64'd8);
    runSched();
`ifdef INSTRET_COUNTER_EN
    check("instret after add", 64'(obsFirstInstret), 64'd1);
`else
    check("instret after add", 64'(obsFirstInstret), 64'd0);
`endif
    check("lw read held cycles", 64'(obsMemRd), 64'd4);
    check("lw regwrite pulses", 64'(obsRegW), 64'd1);

    instr(opLoad, 3'b010, 1'b0, 1'b0, 0, 0, 1'b0);
    check("lw latency", 64'(sched.size()), 64'd5);
    runSched();

    instr(opBeq, 3'b000, 1'b0, 1'b1, 0, 0, 1'b0);
    check("beq taken latency", 64'(sched.size()), 64'd3);
    runSched();
    check("beq taken pc writes", 64'(obsPcW), 64'd2);
    instr(opBeq, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
    check("beq untaken latency", 64'(sched.size()), 64'd3);
    runSched();
    check("beq untaken pc writes", 64'(obsPcW), 64'd1);

    instr(opJal, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
    check("jal latency", 64'(sched.size()), 64'd4);
    runSched();
    check("jal pc writes", 64'(obsPcW), 64'd2);
    check("jal regwrite pulses", 64'(obsRegW), 64'd1);

    instr(7'h7F, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
    runSched();
    check("illegal opcode sticky cycles", 64'(obsIll), 64'd20);
    instr(opR, 3'b001, 1'b0, 1'b0, 0, 0, 1'b0);
    runSched();
    check("illegal funct3 sticky cycles", 64'(obsIll), 64'd20);

    instr(opStore, 3'b010, 1'b0, 1'b0, 1, 2, 1'b1);
    runSched();

    for (int n = 0; n < 120; n++) begin
      k = $urandom_range(0, 19);
      f3 = legalF3[$urandom_range(0, 4)];
      case (k)
        0, 1, 2:    opc = opLoad;
        3, 4, 5:    opc = opStore;
        6, 7, 8, 9: opc = opR;
        10, 11, 12: opc = opI;
        13, 14, 15: opc = opBeq;
        16, 17:     opc = opJal;
        18:         begin opc = opR; f3 = 3'($urandom_range(0, 7)); end
        default: begin
          opc = 7'($urandom);
          if (opc inside {opLoad, opStore, opR, opI, opBeq, opJal}) opc = 7'h7F;
        end
      endcase
      instr(opc, f3, rnd(), rnd(), $urandom_range(0, 3), $urandom_range(0, 3),
            ($urandom_range(0, 9) == 0));
      if (sched.size() > 64) runSched();
    end
    runSched();

`ifdef INSTRET_COUNTER_EN
    pushReset();
    runSched();
    expCount = 32'hFFFF_FFFF;
    instr(opR, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
    instr(opI, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
    force dut.instretCount = 32'hFFFF_FFFF;
    releasePending = 1'b1;
    runSched();
    check("instret wrap then one more", 64'(o_instret), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multicycle RISC-V core. It sequences a shared datapath: one unified instruction/data memory, a single ALU and the register file, with an instruction register, ALUOut and data registers between stages. Each cycle it decodes the current opcode and state into mux selects, write enables and the ALU operation. It waits on a memory-ready handshake for every memory access.

## Interface
Parameters:
- none

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_arst_n  in  1  asynchronous, active-low reset
- i_operand  in  7  opcode, instruction[6:0], from the instruction register
- i_funct3  in  3  instruction[14:12]
- i_funct7bit5  in  1  instruction[30]
- i_zero  in  1  ALU zero flag
- i_memReady  in  1  memory completes the current access this cycle
- o_pcWriteEn  out  1  PC register load
- o_adrSel  out  1  memory address select: 0 = PC, 1 = ALUOut
- o_memReadEn  out  1  memory read request
- o_memWriteEn  out  1  memory write request
- o_irWriteEn  out  1  instruction register and oldPC load
- o_regWriteEn  out  1  register file write
- o_resultSel  out  2  result mux: 00 = ALUOut, 01 = memory data, 10 = ALU result
- o_aluSrcA  out  2  ALU input A: 00 = PC, 01 = oldPC, 10 = rs1
- o_aluSrcB  out  2  ALU input B: 00 = rs2, 01 = immediate, 10 = constant 4
- o_aluLogicOperation  out  4  ALU operation: ADD 0x0, SUB 0x1, AND 0x2, OR 0x3, XOR 0x4, SLT 0x5
- o_illegal  out  1  sticky illegal-instruction flag
- o_instret  out  32  count of retired instructions (see Configuration)

## Operation
- Opcode decode:
  - lw 0000011
  - sw 0100011
  - R-type 0110011
  - I-ALU 0010011
  - beq 1100011
  - jal 1101111
  - any other opcode is illegal
- Unless listed for a state, every enable is 0 and every select is 00.
- FETCH:
  - o_adrSel=0, o_memReadEn=1, srcA=00, srcB=10, ADD, o_resultSel=10.
  - o_irWriteEn and o_pcWriteEn equal i_memReady.
  - Stay in FETCH while i_memReady=0; go to DECODE when i_memReady=1.
- DECODE:
  - srcA=01, srcB=01, ADD (computes the branch/jump target into ALUOut).
  - Next state: lw/sw→MEMADR, R→EXECUTER, I-ALU→EXECUTEI, beq→BEQ, jal→JAL, illegal→ILLEGAL.
- MEMADR: srcA=10, srcB=01, ADD; go to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD:
  - o_adrSel=1, o_memReadEn=1.
  - Hold until i_memReady=1, then go to MEMWB.
- MEMWB: o_resultSel=01, o_regWriteEn=1; go to FETCH.
- MEMWRITE:
  - o_adrSel=1, o_memWriteEn=1, held constant until i_memReady=1, then go to FETCH.
- EXECUTER: srcA=10, srcB=00, ALU op decoded; go to ALUWB.
- EXECUTEI: srcA=10, srcB=01, ALU op decoded; go to ALUWB.
- ALU op decode by funct3:
  - 000: ADD, or SUB when R-type and i_funct7bit5=1
  - 010: SLT
  - 100: XOR
  - 110: OR
  - 111: AND
  - any other funct3 is illegal; DECODE routes it to ILLEGAL.
- ALUWB: o_resultSel=00, o_regWriteEn=1; go to FETCH.
- BEQ:
  - srcA=10, srcB=00, SUB, o_resultSel=00, o_pcWriteEn=i_zero.
  - Go to FETCH.
- JAL:
  - srcA=01, srcB=10, ADD (computes oldPC+4), o_resultSel=00 (target), o_pcWriteEn=1.
  - Go to ALUWB, which writes the return address to rd.
- ILLEGAL:
  - All enables 0, o_illegal=1.
  - Terminal state; only reset exits it.

## Timing
- Outputs are combinational from state plus inputs (Moore, except FETCH strobes and BEQ, which follow i_memReady and i_zero).
- While i_arst_n=0:
  - All outputs are 0 (gated by reset), including o_instret=0.
  - State is FETCH.
- First fetch request is in the first cycle after i_arst_n rises.
- Latency with zero memory wait states:
  - beq: 3 cycles
  - R-type, I-ALU, sw, jal: 4 cycles
  - lw: 5 cycles
- Each cycle of i_memReady=0 adds one cycle in FETCH, MEMREAD or MEMWRITE.
- Memory handshake: request signals and address select stay constant until the cycle where i_memReady=1. The access completes in that cycle.
- i_memReady outside FETCH, MEMREAD or MEMWRITE is ignored.
- Reset asserted mid-access drops all requests immediately. No partial write-enable pulse survives.

## Configuration
- INSTRET_COUNTER_EN defined:
  - o_instret increments by 1 on each transition into FETCH from MEMWB, MEMWRITE (completed), ALUWB or BEQ.
  - jal counts once, through ALUWB.
  - Wraps from 0xFFFFFFFF to 0.
  - Does not count in ILLEGAL.
- INSTRET_COUNTER_EN undefined: no counter flops; o_instret is constant 0.

## Test plan
- Reset, then add (0110011, funct3 000, funct7bit5=0), i_memReady always 1 → states FETCH, DECODE, EXECUTER, ALUWB. o_aluLogicOperation=0x0 in EXECUTER; o_regWriteEn=1 only in cycle 4; o_instret=1.
- lw with i_memReady low 3 cycles in MEMREAD → o_adrSel=1 and o_memReadEn=1 held 4 cycles; MEMWB asserts o_resultSel=01 and o_regWriteEn=1 exactly once.
- beq with i_zero=1, then beq with i_zero=0 → o_pcWriteEn=1 in BEQ only for the first; each takes 3 cycles.
- jal → JAL asserts o_pcWriteEn=1 and srcA=01, srcB=10; ALUWB writes rd; o_instret increases by exactly 1.
- Opcode 0x7F, or R-type with funct3 001 → ILLEGAL after DECODE; o_illegal=1 and all enables 0 for 20 cycles; i_arst_n pulse returns to FETCH with o_illegal=0.
- With INSTRET_COUNTER_EN, preload o_instret near wrap (run until 0xFFFFFFFF via force), retire one instruction → 0x00000000; without the macro, o_instret=0 throughout.
